// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level encodings: arbiter source IDs and lock state.
package core_v_mini_mcu_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_id_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus payload types shared by CPU-side and bus-side blocks.
package obi_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

  typedef struct packed {
    logic                  req;
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_src_id_fifo.sv
// In-order source-ID FIFO: remembers which port issued each outstanding transaction.
module obi_src_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push,
  input  logic                             din,
  input  logic                             pop,
  output logic                             head,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             empty,
  output logic                             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Overflow/underflow guards; callers should never rely on them.
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Status and head view, all from registered state.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
  end

endmodule

// File: rtl/cpu_obi_port_arbiter.sv
// Merges the core instruction and data OBI ports onto one bus manager port.
module cpu_obi_port_arbiter
  import obi_pkg::*;
  import core_v_mini_mcu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_PRIORITY   = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t                             instr_req_i,
  output obi_resp_t                            instr_resp_o,
  input  obi_req_t                             data_req_i,
  output obi_resp_t                            data_resp_o,
  output obi_req_t                             bus_req_o,
  input  obi_resp_t                            bus_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  arb_state_e       state_q, state_d;
  src_id_e          sel_q, sel_d;
  src_id_e          last_q, last_d;
  src_id_e          sel_c;
  logic             sel_req_c;
  logic             hs_c;
  logic             pop_c;
  logic             fifo_head;
  logic [CNT_W-1:0] cnt_q;
  logic             fifo_empty;
  logic             fifo_full;

  obi_src_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs_c),
    .din   (sel_c),
    .pop   (pop_c),
    .head  (fifo_head),
    .count (cnt_q),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Lock state, held selection and round-robin history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      sel_q   <= SRC_INSTR;
      last_q  <= SRC_INSTR;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // Selection, request mux, grant/response routing and next state.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    sel_c        = SRC_INSTR;
    bus_req_o    = '0;
    instr_resp_o = '0;
    data_resp_o  = '0;

    if (state_q == ARB_LOCKED) begin
      sel_c = sel_q;
    end else if (instr_req_i.req && data_req_i.req) begin
      if (DATA_PRIORITY) sel_c = SRC_DATA;
      else               sel_c = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else if (data_req_i.req) begin
      sel_c = SRC_DATA;
    end

    bus_req_o     = (sel_c == SRC_DATA) ? data_req_i : instr_req_i;
    sel_req_c     = bus_req_o.req;
    // Limit uses the registered count only, so a freed slot is usable next cycle.
    bus_req_o.req = sel_req_c & ~fifo_full & ~rst_i;

    hs_c  = bus_req_o.req & bus_resp_i.gnt;
    pop_c = bus_resp_i.rvalid & ~fifo_empty & ~rst_i;

    instr_resp_o.gnt    = hs_c & (sel_c == SRC_INSTR);
    data_resp_o.gnt     = hs_c & (sel_c == SRC_DATA);
    instr_resp_o.rdata  = bus_resp_i.rdata;
    data_resp_o.rdata   = bus_resp_i.rdata;
    instr_resp_o.rvalid = pop_c & (src_id_e'(fifo_head) == SRC_INSTR);
    data_resp_o.rvalid  = pop_c & (src_id_e'(fifo_head) == SRC_DATA);

    case (state_q)
      ARB_IDLE: begin
        if (bus_req_o.req && !bus_resp_i.gnt) begin
          state_d = ARB_LOCKED;
          sel_d   = sel_c;
        end
      end
      ARB_LOCKED: begin
        // Also release if the held requester withdraws, so a misbehaving core cannot wedge the port.
        if (hs_c || !sel_req_c) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (hs_c) last_d = sel_c;

    outstanding_o = rst_i ? '0 : cnt_q;
  end

  // A response with nothing outstanding is a bus protocol violation.
  always @(posedge clk_i) begin
    if (!rst_i) assert (!(bus_resp_i.rvalid && fifo_empty));
  end

endmodule

// File: tb/tb_cpu_obi_port_arbiter.sv
// Directed bench for cpu_obi_port_arbiter (round-robin and data-priority builds).
module tb_cpu_obi_port_arbiter;
  import obi_pkg::*;

  logic      clk;
  logic      rst;
  obi_req_t  instr_req, data_req, bus_req;
  obi_resp_t instr_resp, data_resp, bus_resp;
  logic [1:0] outstanding;

  obi_req_t  p_instr_req, p_data_req, p_bus_req;
  obi_resp_t p_instr_resp, p_data_resp, p_bus_resp;
  logic [1:0] p_outstanding;

  int n_vec = 0;
  int n_err = 0;

  cpu_obi_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_resp_o(instr_resp),
    .data_req_i(data_req), .data_resp_o(data_resp),
    .bus_req_o(bus_req), .bus_resp_i(bus_resp),
    .outstanding_o(outstanding)
  );

  cpu_obi_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) dut_p (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(p_instr_req), .instr_resp_o(p_instr_resp),
    .data_req_i(p_data_req), .data_resp_o(p_data_resp),
    .bus_req_o(p_bus_req), .bus_resp_i(p_bus_resp),
    .outstanding_o(p_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive the round-robin DUT for one cycle (called right after a negedge).
  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da,
                       input logic g, input logic rv, input logic [31:0] rd);
    instr_req       = '0;
    instr_req.req   = ir;
    instr_req.addr  = ia;
    instr_req.be    = 4'hF;
    data_req        = '0;
    data_req.req    = dr;
    data_req.addr   = da;
    data_req.be     = 4'hF;
    data_req.we     = 1'b1;
    data_req.wdata  = da ^ 32'h5A5A_0000;
    bus_resp        = '0;
    bus_resp.gnt    = g;
    bus_resp.rvalid = rv;
    bus_resp.rdata  = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    p_instr_req = '0; p_data_req = '0; p_bus_resp = '0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (bus_req.req !== 1'b0 || instr_resp.gnt !== 1'b0 || data_resp.gnt !== 1'b0) begin
      n_err++;
      $display("FAIL reset_gating: req=%b igt=%b dgt=%b want 0 0 0", bus_req.req, instr_resp.gnt, data_resp.gnt);
    end
    n_vec++;
    if (outstanding !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (bus_req.req !== 1'b0 || outstanding !== 2'd0) begin
      n_err++;
      $display("FAIL reset_release: req=%b out=%0d want 0 0", bus_req.req, outstanding);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive(1'b1, 32'h180, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (instr_resp.gnt !== 1'b1 || data_resp.gnt !== 1'b0 || bus_req.addr !== 32'h180 || bus_req.req !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: igt=%b dgt=%b addr=%h req=%b want 1 0 00000180 1",
               instr_resp.gnt, data_resp.gnt, bus_req.addr, bus_req.req);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    #1;
    n_vec++;
    if (instr_resp.rvalid !== 1'b1 || instr_resp.rdata !== 32'hDEADBEEF || data_resp.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_rvalid: irv=%b rdata=%h drv=%b want 1 deadbeef 0",
               instr_resp.rvalid, instr_resp.rdata, data_resp.rvalid);
    end
    n_vec++;
    if (outstanding !== 2'd1) begin
      n_err++;
      $display("FAIL single_outstanding: got %0d want 1", outstanding);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (outstanding !== 2'd0) begin
      n_err++;
      $display("FAIL single_drain: got %0d want 0", outstanding);
    end
  endtask

  // last grant was instr, so data wins first: D I D I, responses one cycle behind.
  task automatic test_round_robin();
    logic exp_d [4];
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) drive(1'b1, 32'h300 + 32'(k), 1'b1, 32'h700 + 32'(k), 1'b1, (k > 0), 32'h1000 + 32'(k));
      else       drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000 + 32'(k));
      #1;
      if (k < 4) begin
        n_vec++;
        if (data_resp.gnt !== exp_d[k] || instr_resp.gnt !== ~exp_d[k]) begin
          n_err++;
          $display("FAIL rr_grant[%0d]: dgt=%b igt=%b want %b %b", k, data_resp.gnt, instr_resp.gnt, exp_d[k], ~exp_d[k]);
        end
      end
      if (k > 0) begin
        n_vec++;
        if (data_resp.rvalid !== exp_d[k-1] || instr_resp.rvalid !== ~exp_d[k-1]) begin
          n_err++;
          $display("FAIL rr_rvalid[%0d]: drv=%b irv=%b want %b %b", k, data_resp.rvalid, instr_resp.rvalid, exp_d[k-1], ~exp_d[k-1]);
        end
      end
    end
  endtask

  task automatic test_lock();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h1000, (k > 0), 32'h2000, 1'b0, 1'b0, 32'h0);
      #1;
      n_vec++;
      if (bus_req.addr !== 32'h1000 || bus_req.req !== 1'b1 || data_resp.gnt !== 1'b0 || instr_resp.gnt !== 1'b0) begin
        n_err++;
        $display("FAIL lock_hold[%0d]: addr=%h req=%b dgt=%b igt=%b want 00001000 1 0 0",
                 k, bus_req.addr, bus_req.req, data_resp.gnt, instr_resp.gnt);
      end
    end
    @(negedge clk);
    drive(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (instr_resp.gnt !== 1'b1 || data_resp.gnt !== 1'b0 || bus_req.addr !== 32'h1000) begin
      n_err++;
      $display("FAIL lock_release: igt=%b dgt=%b addr=%h want 1 0 00001000", instr_resp.gnt, data_resp.gnt, bus_req.addr);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 1'b1, 32'hA5A5_0001);
    #1;
    n_vec++;
    if (data_resp.gnt !== 1'b1 || bus_req.addr !== 32'h2000 || bus_req.we !== 1'b1 || instr_resp.rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL lock_next: dgt=%b addr=%h we=%b irv=%b want 1 00002000 1 1",
               data_resp.gnt, bus_req.addr, bus_req.we, instr_resp.rvalid);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0002);
    #1;
    n_vec++;
    if (data_resp.rvalid !== 1'b1 || instr_resp.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL lock_resp: drv=%b irv=%b want 1 0", data_resp.rvalid, instr_resp.rvalid);
    end
  endtask

  // Leaves two transactions outstanding for the reset test.
  task automatic test_limit();
    @(negedge clk);
    drive(1'b1, 32'h400, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (instr_resp.gnt !== 1'b1) begin
      n_err++;
      $display("FAIL limit_g0: igt=%b want 1", instr_resp.gnt);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (data_resp.gnt !== 1'b1) begin
      n_err++;
      $display("FAIL limit_g1: dgt=%b want 1", data_resp.gnt);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (outstanding !== 2'd2 || bus_req.req !== 1'b0 || instr_resp.gnt !== 1'b0 || data_resp.gnt !== 1'b0) begin
      n_err++;
      $display("FAIL limit_full: out=%0d req=%b igt=%b dgt=%b want 2 0 0 0",
               outstanding, bus_req.req, instr_resp.gnt, data_resp.gnt);
    end
    @(negedge clk);
    drive(1'b1, 32'h400, 1'b1, 32'h800, 1'b1, 1'b1, 32'h0000_0444);
    #1;
    n_vec++;
    if (bus_req.req !== 1'b0 || instr_resp.rvalid !== 1'b1 || data_resp.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL limit_pop: req=%b irv=%b drv=%b want 0 1 0", bus_req.req, instr_resp.rvalid, data_resp.rvalid);
    end
    @(negedge clk);
    drive(1'b1, 32'h400, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (bus_req.req !== 1'b1 || instr_resp.gnt !== 1'b1 || outstanding !== 2'd1) begin
      n_err++;
      $display("FAIL limit_reassert: req=%b igt=%b out=%0d want 1 1 1", bus_req.req, instr_resp.gnt, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    #1;
    n_vec++;
    if (outstanding !== 2'd0 || bus_req.req !== 1'b0 || instr_resp.gnt !== 1'b0 || instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: out=%0d req=%b igt=%b irv=%b drv=%b want 0 0 0 0 0",
               outstanding, bus_req.req, instr_resp.gnt, instr_resp.rvalid, data_resp.rvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h180, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (instr_resp.gnt !== 1'b1 || bus_req.addr !== 32'h180) begin
      n_err++;
      $display("FAIL rst_mid_fresh: igt=%b addr=%h want 1 00000180", instr_resp.gnt, bus_req.addr);
    end
    @(negedge clk);
    drive(1'b1, 32'h184, 1'b1, 32'h2004, 1'b1, 1'b1, 32'hCAFE_F00D);
    #1;
    n_vec++;
    if (instr_resp.rvalid !== 1'b1 || data_resp.rvalid !== 1'b0 || data_resp.gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_resp: irv=%b drv=%b dgt=%b want 1 0 1", instr_resp.rvalid, data_resp.rvalid, data_resp.gnt);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (outstanding !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid_drain: out=%0d want 0", outstanding);
    end
  endtask

  task automatic test_priority();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      p_instr_req       = '0;
      p_instr_req.req   = (k < 4);
      p_instr_req.addr  = 32'h100;
      p_data_req        = '0;
      p_data_req.req    = (k < 4);
      p_data_req.addr   = 32'h200 + 32'(k);
      p_bus_resp        = '0;
      p_bus_resp.gnt    = (k < 4);
      p_bus_resp.rvalid = (k > 0);
      p_bus_resp.rdata  = 32'h9000 + 32'(k);
      #1;
      if (k < 4) begin
        n_vec++;
        if (p_data_resp.gnt !== 1'b1 || p_instr_resp.gnt !== 1'b0 || p_bus_req.addr !== 32'h200 + 32'(k)) begin
          n_err++;
          $display("FAIL prio_grant[%0d]: dgt=%b igt=%b addr=%h want 1 0 %h",
                   k, p_data_resp.gnt, p_instr_resp.gnt, p_bus_req.addr, 32'h200 + 32'(k));
        end
      end
      if (k > 0) begin
        n_vec++;
        if (p_data_resp.rvalid !== 1'b1 || p_instr_resp.rvalid !== 1'b0) begin
          n_err++;
          $display("FAIL prio_rvalid[%0d]: drv=%b irv=%b want 1 0", k, p_data_resp.rvalid, p_instr_resp.rvalid);
        end
      end
    end
    @(negedge clk);
    p_bus_resp = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_limit();
    test_reset_mid();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_obi_port_arbiter.md
# cpu_obi_port_arbiter

Two-into-one OBI arbiter between the CPU subsystem and the system bus. It merges the core instruction port and data port onto a single OBI manager port, for area-reduced configurations with one bus master per core. Arbitration is round-robin or fixed-priority, with request locking that satisfies OBI stability rules. Outstanding transactions are tracked in an in-order source-ID FIFO so that each `rvalid`/`rdata` returns to the requester that issued it.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered transactions on the shared port; legal range 1..8.
- `DATA_PRIORITY`, default 0: 0 selects round-robin; 1 selects fixed priority, data over instruction.

Ports:
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset; synchronous, active-high.
- `instr_req_i`  in  obi_req_t: core instruction request (`req`, `addr`, `we`, `be`, `wdata`).
- `instr_resp_o`  out  obi_resp_t: `gnt`, `rvalid`, `rdata` back to the instruction port.
- `data_req_i`  in  obi_req_t: core data request.
- `data_resp_o`  out  obi_resp_t: response back to the data port.
- `bus_req_o`  out  obi_req_t: merged request to the system bus.
- `bus_resp_i`  in  obi_resp_t: system bus `gnt`, `rvalid`, `rdata`.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING+1): current outstanding count, for debug and performance counters.

## Operation
- **Eligibility.**
  - A requester is eligible when its `req` is 1 and `cnt_q < MAX_OUTSTANDING`.
  - At `cnt_q == MAX_OUTSTANDING`, `bus_req_o.req` = 0 and both `gnt` outputs are 0.
- **Selection, state IDLE** (no lock):
  - Round-robin picks the requester not granted last, tracked in `last_q`; `last_q` resets to instr, so data wins the first tie.
  - Priority mode always picks data when both are eligible.
- **State LOCKED.**
  - Entered when `bus_req_o.req` = 1 and `bus_resp_i.gnt` = 0.
  - `sel_q` holds the selection and the mux ignores the other requester until `gnt`.
  - Returns to IDLE in the cycle `gnt` = 1.
- **Request mux.**
  - `bus_req_o` is the selected requester's fields.
  - `bus_req_o.req` equals the selected `req`, gated by the outstanding limit.
- **Grant.**
  - `bus_resp_i.gnt` is routed only to the selected requester's `gnt`; the other sees 0.
  - A handshake is `req & gnt`. On a handshake, push the source ID (0 = instr, 1 = data) into the ID FIFO and update `last_q`.
- **Response.**
  - `bus_resp_i.rvalid` is routed to the requester named by the FIFO head, which is then popped.
  - `rdata` is broadcast to both ports; only the routed port sees `rvalid` = 1.
- **Counter.** `cnt_q` changes by +1 on push, -1 on pop, and 0 on simultaneous push and pop.
- **Error case.** `rvalid` with an empty FIFO is a protocol error: it is dropped, nothing is routed, and a simulation assertion fires.
- **Reset mid-transaction.**
  - FIFO, `cnt_q`, `sel_q` and `last_q` are cleared, and the state returns to IDLE.
  - Responses still in flight from the bus are then unexpected; the system reset must cover the bus too.
- **Reset outputs.** While `rst_i` = 1, all `req`, `gnt` and `rvalid` outputs are 0 and `outstanding_o` is 0.

## Timing
- **Request and grant latency.** Zero-cycle combinational paths: `*_req_i` → `bus_req_o` and `bus_resp_i.gnt` → `*_resp_o.gnt`. The arbiter adds no request latency.
- **Response latency.** Zero-cycle combinational path `bus_resp_i.rvalid` → selected `rvalid`. FIFO head and count are registered, so there is no `gnt` → `rvalid` combinational loop.
- **Outstanding limit.** Gating uses registered `cnt_q` only: a slot freed by `rvalid` in cycle N is grantable in N+1. Consequently, with `MAX_OUTSTANDING`=1, throughput is at most one transaction per 2 cycles.
- **OBI stability.** `bus_req_o` address, `we`, `be` and `wdata` are stable from `req` rise until `gnt`, guaranteed by LOCKED. OBI requires the requesters to hold their own signals stable.
- **Ordering.** Responses on the shared port are in order; the FIFO never reorders.
- **FIFO sizing.** Depth is `MAX_OUTSTANDING`, so push-when-full is impossible by construction.

## Structure
- `obi_req_t` and `obi_resp_t` come from `obi_pkg`.
- Source-ID encoding (`SRC_INSTR`=0, `SRC_DATA`=1) and the lock state enum go in `core_v_mini_mcu_pkg`.
- One sub-module: `obi_src_id_fifo`, a 1-bit-wide, `MAX_OUTSTANDING`-deep synchronous FIFO with `push`, `pop`, `head`, `count`, `empty` and `full`. The top module holds the arbitration and lock logic.
- Placement: instantiated next to `cpu_subsystem` in the MCU top.

## Test plan
- **Single requester.** instr reads 0x180 with bus `gnt` same cycle and `rvalid` next cycle, `rdata`=0xDEADBEEF → `instr_resp_o.gnt`=1 in cycle 0, `rvalid`=1 with 0xDEADBEEF in cycle 1, and `data_resp_o.rvalid` stays 0.
- **Round-robin fairness.** Both request continuously, `gnt` always 1, `MAX_OUTSTANDING`=2, `rvalid` 1 cycle later → grants alternate data, instr, data, instr, and each `rvalid` returns to the matching port.
- **Lock.** Instr requests 0x1000 with `gnt` held 0 for 3 cycles while data requests 0x2000 → `bus_req_o.addr` stays 0x1000 all 3 cycles; data is granted next, after instr's `gnt`.
- **Limit.** `MAX_OUTSTANDING`=2, two grants with no `rvalid` → `outstanding_o`=2 and `bus_req_o.req`=0 despite pending requests; one `rvalid` → `req` reasserts the next cycle.
- **Priority mode.** `DATA_PRIORITY`=1, both requesting for 4 cycles, `gnt`=1 → data granted all 4 cycles and instr `gnt`=0 throughout.
- **Reset mid-operation.** `rst_i` pulsed for 1 cycle with 2 outstanding → next cycle `outstanding_o`=0, arbiter in IDLE, and a fresh instr request is granted normally.
